// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, bit-mixing functions and the compression FSM state type.
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINISH} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial chaining value H0..H7 for the first block of a message.
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_ch.sv
// Choose function: each bit of e selects between the matching bits of f and g.
module sha256_ch (
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  output logic [31:0] ch
);

  assign ch = (e & f) ^ (~e & g);

endmodule

// File: rtl/sha256_compress.sv
// One 512-bit block through 64 SHA-256 rounds at one round per clock, with a rolling
// 16-word message schedule; the result is folded into the chaining value on FINISH.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  state_t       state;
  logic [5:0]   t;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] hcap;
  logic [31:0]  w [0:15];

  logic [31:0]  ch_efg;
  logic [31:0]  t1, t2, w_next;

  sha256_ch u_ch (
    .e  (e),
    .f  (f),
    .g  (g),
    .ch (ch_efg)
  );

  // w[0] is W[t]; the appended word is W[t+16] built from the current window.
  always_comb begin
    t1     = h + big_sigma1(e) + ch_efg + K[t] + w[0];
    t2     = big_sigma0(a) + maj(a, b, c);
    w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      t        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hash_out <= '0;
      hcap     <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            {a, b, c, d, e, f, g, h} <= hash_in;
            hcap  <= hash_in;
            for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
            t     <= '0;
            busy  <= 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_next;
          t     <= t + 6'd1;
          if (t == 6'd63) state <= FINISH;
        end
        FINISH: begin
          hash_out <= {hcap[255:224] + a, hcap[223:192] + b,
                       hcap[191:160] + c, hcap[159:128] + d,
                       hcap[127:96]  + e, hcap[95:64]   + f,
                       hcap[63:32]   + g, hcap[31:0]    + h};
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Directed known-answer bench for sha256_compress: FIPS 180 examples, latency, start
// gating, mid-run reset and input stability after acceptance.
module tb_sha256_compress;
  import sha256_pkg::*;

  logic         clk;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  int checks = 0;
  int errors = 0;

  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_compress dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 16; i++) block_in[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++)  hash_in[32*i +: 32]  = $urandom;
  endtask

  // Presents a block at the falling edge; returns just after the accepting edge.
  task automatic accept(input logic [511:0] blk, input logic [255:0] h, output logic busy_after);
    @(negedge clk);
    block_in = blk;
    hash_in  = h;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    busy_after = busy;
  endtask

  // Counts edges after acceptance until done, bounded.
  task automatic wait_done(input bit scramble, output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      if (scramble) randomize_inputs();
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  logic b_acc;
  int   lat;
  int   ndone;
  int   first_lat;
  logic [255:0] cap;

  initial begin
    start    = 1'b0;
    block_in = '0;
    hash_in  = '0;
    rst      = 1'b1;
    #2 rst   = 1'b0;
    #3;
    chk("reset_busy", {255'h0, busy}, 256'h0);
    chk("reset_done", {255'h0, done}, 256'h0);
    chk("reset_hash", hash_out, 256'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Empty message
    accept(BLK_EMPTY, IV, b_acc);
    chk("empty_busy_at_accept", {255'h0, b_acc}, 256'h1);
    wait_done(1'b0, lat);
    chk("empty_latency", 256'(lat), 256'd65);
    chk("empty_digest", hash_out, DIG_EMPTY);
    chk("empty_busy_in_done", {255'h0, busy}, 256'h0);
    @(posedge clk); #1;
    chk("empty_done_clears", {255'h0, done}, 256'h0);
    chk("empty_hash_holds", hash_out, DIG_EMPTY);

    // "abc"
    accept(BLK_ABC, IV, b_acc);
    wait_done(1'b0, lat);
    chk("abc_latency", 256'(lat), 256'd65);
    chk("abc_digest", hash_out, DIG_ABC);

    // Two-block chain, second block accepted in the done cycle
    accept(BLK_TWO1, IV, b_acc);
    wait_done(1'b0, lat);
    chk("two_blk1_latency", 256'(lat), 256'd65);
    cap = hash_out;
    accept(BLK_TWO2, cap, b_acc);
    chk("two_blk2_busy_at_accept", {255'h0, b_acc}, 256'h1);
    wait_done(1'b0, lat);
    chk("two_blk2_latency", 256'(lat), 256'd65);
    chk("two_digest", hash_out, DIG_TWO);

    // start pulses during rounds must be ignored
    accept(BLK_ABC, IV, b_acc);
    ndone     = 0;
    first_lat = 0;
    cap       = '0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 10 || k == 40) begin
        start    = 1'b1;
        block_in = BLK_EMPTY;
        hash_in  = ~IV;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_lat = k;
          cap       = hash_out;
        end
      end
    end
    start = 1'b0;
    chk("ignore_done_count", 256'(ndone), 256'd1);
    chk("ignore_latency", 256'(first_lat), 256'd65);
    chk("ignore_digest", cap, DIG_ABC);

    // Reset during round 30
    accept(BLK_EMPTY, IV, b_acc);
    repeat (30) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("midreset_busy", {255'h0, busy}, 256'h0);
    chk("midreset_done", {255'h0, done}, 256'h0);
    chk("midreset_hash", hash_out, 256'h0);
    @(negedge clk) rst = 1'b1;
    accept(BLK_ABC, IV, b_acc);
    wait_done(1'b0, lat);
    chk("post_reset_latency", 256'(lat), 256'd65);
    chk("post_reset_digest", hash_out, DIG_ABC);

    // Inputs scrambled every cycle after acceptance
    accept(BLK_ABC, IV, b_acc);
    wait_done(1'b1, lat);
    chk("scramble_latency", 256'(lat), 256'd65);
    chk("scramble_digest", hash_out, DIG_ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
